axi_lite_mem_sequencer: RTL and testbench

- AXI-Lite master-side controller that sequences the memory-mapped slave through a write-then-readback pass.
- On start, writes N words of a seed-derived pattern to consecutive word addresses, reads them back, and compares each readback.
- Reports busy, a done pulse, a mismatch count and a response-error count.
- Sits between the test/config logic and the AXI-Lite bus.

---
 rtl/axi_lite_pkg.sv | 17 +
 rtl/sat_counter.sv | 23 ++
 rtl/axi_lite_mem_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_axi_lite_mem_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite write-then-readback sequencer: FSM states and response codes.
// No logic here; latency and backpressure are properties of the importing modules.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        DONE
    } seq_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; count updates one cycle after inc/clr.
// No backpressure: clr wins over inc, and inc is ignored once the count is all ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             axi_aclk,
    input  logic             axi_aresetn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/axi_lite_mem_sequencer.sv
// Writes N seed+i words to consecutive addresses, reads them back and counts mismatches/bad responses.
// Bus outputs registered (first awvalid 1 cycle after start); one transaction in flight, stalls on any ready/valid.
module axi_lite_mem_sequencer
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [CNT_WIDTH-1:0]    word_count,
    input  logic [DATA_WIDTH-1:0]   seed,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    mismatch_cnt,
    output logic [CNT_WIDTH-1:0]    resp_err_cnt,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    seq_state_t             state_q, state_d;
    logic [CNT_WIDTH-1:0]   idx_q, idx_d, n_q, n_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d, addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  seed_q, seed_d, data_q, data_d;
    logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                   arvalid_q, arvalid_d, rready_q, rready_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic                   cnt_clr, mism_inc, resp_inc, last;

    assign last = (idx_q == (n_q - CNT_WIDTH'(1)));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        base_d    = base_q;
        seed_d    = seed_q;
        addr_d    = addr_q;
        data_d    = data_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_clr   = 1'b0;
        mism_inc  = 1'b0;
        resp_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    n_d     = word_count;
                    seed_d  = seed;
                    addr_d  = base_addr;
                    data_d  = seed;
                    idx_d   = '0;
                    cnt_clr = 1'b1;
                    if (word_count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // A dropped valid means that channel already handshook in this write.
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    resp_inc = (m_axi_bresp != RESP_OKAY);
                    if (last) begin
                        idx_d     = '0;
                        addr_d    = base_q;
                        data_d    = seed_q;
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end else begin
                        idx_d     = idx_q + CNT_WIDTH'(1);
                        addr_d    = addr_q + ADDR_STEP;
                        data_d    = data_q + DATA_WIDTH'(1);
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rready_d = 1'b0;
                    resp_inc = (m_axi_rresp != RESP_OKAY);
                    mism_inc = (m_axi_rdata != data_q);
                    if (last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d     = idx_q + CNT_WIDTH'(1);
                        addr_d    = addr_q + ADDR_STEP;
                        data_d    = data_q + DATA_WIDTH'(1);
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            base_q    <= '0;
            seed_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            base_q    <= base_d;
            seed_q    <= seed_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_mismatch_cnt (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .clr         (cnt_clr),
        .inc         (mism_inc),
        .count       (mismatch_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_resp_err_cnt (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .clr         (cnt_clr),
        .inc         (resp_inc),
        .count       (resp_err_cnt)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_mem_sequencer.sv
// Directed bench for axi_lite_mem_sequencer with a word-addressed AXI-Lite memory slave model.
module tb_axi_lite_mem_sequencer;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [7:0]  word_count = '0;
    logic [31:0] seed = '0;
    logic        busy, done;
    logic [7:0]  mismatch_cnt, resp_err_cnt;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    // slave knobs and logs
    int          aw_delay = 0, w_delay = 0;
    int          corrupt_idx = -1, bresp_err_idx = -1, rresp_err_idx = -1;
    logic        corrupt_all = 1'b0, err_all = 1'b0, log_clr = 1'b0;
    int          wr_n, rd_n, aw_hs_n, w_hs_n, done_n, stab_viol, aw_wait, w_wait;
    logic [31:0] mem [64];
    logic [7:0]  wr_addr_log [256];
    logic [31:0] wr_data_log [256];
    logic [7:0]  rd_addr_log [256];
    logic        aw_got, w_got, aw_hold, w_hold;
    logic [7:0]  aw_a, aw_prev;
    logic [31:0] w_d, w_prev;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_lite_mem_sequencer dut (
        .axi_aclk(clk), .axi_aresetn(rstn), .start(start), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .busy(busy), .done(done),
        .mismatch_cnt(mismatch_cnt), .resp_err_cnt(resp_err_cnt),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    assign awready = (aw_delay == 0) ? 1'b1 : (awvalid && (aw_wait >= aw_delay));
    assign wready  = (w_delay == 0)  ? 1'b1 : (wvalid && (w_wait >= w_delay));
    assign arready = 1'b1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            aw_got = 1'b0; w_got = 1'b0; aw_hold = 1'b0; w_hold = 1'b0;
            aw_wait = 0; w_wait = 0;
        end else begin
            if (log_clr) begin
                wr_n = 0; rd_n = 0; aw_hs_n = 0; w_hs_n = 0; done_n = 0; stab_viol = 0;
            end
            if (aw_hold && awvalid && (awaddr != aw_prev)) stab_viol++;
            if (w_hold && wvalid && (wdata != w_prev)) stab_viol++;
            aw_hold = awvalid && !awready; aw_prev = awaddr;
            w_hold  = wvalid && !wready;   w_prev  = wdata;
            if (awvalid && !awready) aw_wait++; else aw_wait = 0;
            if (wvalid && !wready) w_wait++; else w_wait = 0;
            if (awvalid && awready) begin aw_hs_n++; aw_got = 1'b1; aw_a = awaddr; end
            if (wvalid && wready) begin w_hs_n++; w_got = 1'b1; w_d = wdata; end
            if (bvalid && bready) bvalid <= 1'b0;
            if (aw_got && w_got) begin
                mem[aw_a[7:2]] = w_d;
                wr_addr_log[wr_n[7:0]] = aw_a;
                wr_data_log[wr_n[7:0]] = w_d;
                bresp  <= (err_all || wr_n == bresp_err_idx) ? RESP_SLVERR : RESP_OKAY;
                bvalid <= 1'b1;
                wr_n++;
                aw_got = 1'b0; w_got = 1'b0;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rd_addr_log[rd_n[7:0]] = araddr;
                rdata  <= mem[araddr[7:2]] ^ ((corrupt_all || rd_n == corrupt_idx) ? 32'h1 : 32'h0);
                rresp  <= (err_all || rd_n == rresp_err_idx) ? RESP_SLVERR : RESP_OKAY;
                rvalid <= 1'b1;
                rd_n++;
            end
            if (done) done_n++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_pass(input logic [7:0] b, input logic [7:0] n, input logic [31:0] s);
        @(negedge clk); log_clr = 1'b1;
        @(negedge clk); log_clr = 1'b0;
        base_addr = b; word_count = n; seed = s; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk(tag, seen, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, awvalid, wvalid, bready, arvalid, rready}, 7'b0);
        chk("reset_counters", {mismatch_cnt, resp_err_cnt}, 16'h0);
        rstn = 1'b1;
        @(negedge clk);

        // clean pass, with a start pulse mid-pass that must be ignored
        start_pass(8'h10, 8'd4, 32'hA5A50000);
        chk("first_valids", {busy, awvalid, wvalid}, 3'b111);
        repeat (2) @(negedge clk);
        base_addr = 8'h80; word_count = 8'd1; seed = 32'h0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("t1_done_seen");
        chk("t1_wr_n", wr_n, 4);
        chk("t1_rd_n", rd_n, 4);
        chk("t1_addr0", wr_addr_log[0], 8'h10);
        chk("t1_addr3", wr_addr_log[3], 8'h1C);
        chk("t1_data2", wr_data_log[2], 32'hA5A50002);
        chk("t1_rdaddr3", rd_addr_log[3], 8'h1C);
        chk("t1_mism", mismatch_cnt, 8'd0);
        chk("t1_resp", resp_err_cnt, 8'd0);
        chk("t1_done_once", done_n, 1);
        chk("t1_idle", {busy, done}, 2'b00);

        // corrupted readback of word 2
        corrupt_idx = 2;
        start_pass(8'h10, 8'd4, 32'hA5A50000);
        wait_done("t2_done_seen");
        chk("t2_mism", mismatch_cnt, 8'd1);
        chk("t2_resp", resp_err_cnt, 8'd0);
        corrupt_idx = -1;

        // SLVERR on write 1 and read 3
        bresp_err_idx = 1; rresp_err_idx = 3;
        start_pass(8'h10, 8'd4, 32'hA5A50000);
        wait_done("t3_done_seen");
        chk("t3_resp", resp_err_cnt, 8'd2);
        chk("t3_mism", mismatch_cnt, 8'd0);
        chk("t3_txns", wr_n + rd_n, 8);
        bresp_err_idx = -1; rresp_err_idx = -1;

        // awready delayed, wready immediate
        aw_delay = 3;
        start_pass(8'h20, 8'd2, 32'h12340000);
        chk("t4a_both_valid", {awvalid, wvalid}, 2'b11);
        @(negedge clk);
        chk("t4a_w_dropped", {awvalid, wvalid}, 2'b10);
        wait_done("t4a_done_seen");
        chk("t4a_aw_hs", aw_hs_n, 2);
        chk("t4a_w_hs", w_hs_n, 2);
        chk("t4a_data1", wr_data_log[1], 32'h12340001);
        chk("t4a_stable", stab_viol, 0);
        chk("t4a_mism", mismatch_cnt, 8'd0);
        aw_delay = 0;

        // reverse: wready delayed, awready immediate
        w_delay = 3;
        start_pass(8'h30, 8'd2, 32'h55AA0010);
        @(negedge clk);
        chk("t4b_aw_dropped", {awvalid, wvalid}, 2'b01);
        wait_done("t4b_done_seen");
        chk("t4b_aw_hs", aw_hs_n, 2);
        chk("t4b_w_hs", w_hs_n, 2);
        chk("t4b_addr1", wr_addr_log[1], 8'h34);
        chk("t4b_stable", stab_viol, 0);
        w_delay = 0;

        // address wrap at top of space
        start_pass(8'hF8, 8'd3, 32'hFFFFFFFF);
        wait_done("t5_done_seen");
        chk("t5_addr0", wr_addr_log[0], 8'hF8);
        chk("t5_addr1", wr_addr_log[1], 8'hFC);
        chk("t5_addr2", wr_addr_log[2], 8'h00);
        chk("t5_data2", wr_data_log[2], 32'h00000001);
        chk("t5_rdaddr2", rd_addr_log[2], 8'h00);
        chk("t5_mism", mismatch_cnt, 8'd0);

        // zero-length pass
        @(negedge clk); log_clr = 1'b1;
        @(negedge clk); log_clr = 1'b0;
        word_count = 8'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t6_done_next", {done, busy, awvalid, wvalid, arvalid}, 5'b10000);
        @(negedge clk);
        chk("t6_done_pulse", done, 1'b0);
        repeat (2) @(negedge clk);
        chk("t6_no_traffic", wr_n + rd_n, 0);

        // saturation: every write/read errors and every readback mismatches
        corrupt_all = 1'b1; err_all = 1'b1;
        start_pass(8'h00, 8'd255, 32'h00000100);
        wait_done("t7_done_seen");
        chk("t7_mism_sat", mismatch_cnt, 8'hFF);
        chk("t7_resp_sat", resp_err_cnt, 8'hFF);
        corrupt_all = 1'b0; err_all = 1'b0;

        // reset during the second read of an 8-word pass
        start_pass(8'h40, 8'd8, 32'hCAFE0000);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (arvalid && rd_n == 1) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            chk("t8_reached_read2", seen, 1'b1);
        end
        rstn = 1'b0;
        #1;
        chk("t8_async_drop", {busy, done, awvalid, wvalid, bready, arvalid, rready}, 7'b0);
        repeat (3) @(negedge clk);
        chk("t8_no_done", done_n, 0);
        rstn = 1'b1;
        start_pass(8'h40, 8'd4, 32'hBEEF0000);
        wait_done("t8_done_seen");
        chk("t8_wr_n", wr_n, 4);
        chk("t8_data3", wr_data_log[3], 32'hBEEF0003);
        chk("t8_counters", {mismatch_cnt, resp_err_cnt}, 16'h0);
        chk("t8_done_once", done_n, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
